// File: rtl/id_ex_stage_reg_if.sv
// Decode/execute boundary bundle: hazard selects and decoded fields in,
// registered execute fields and upstream hold signals out.
interface id_ex_stage_reg_if #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned PC_W   = 32,
  parameter int unsigned CTRL_W = 16,
  parameter int unsigned CNT_W  = 16
);
  logic              load_use_hazard;
  logic              pop_jmp_hazard;
  logic              flush;
  logic [CTRL_W-1:0] id_ctrl;
  logic [DATA_W-1:0] id_rs_data;
  logic [DATA_W-1:0] id_rd_data;
  logic [2:0]        id_rs_addr;
  logic [2:0]        id_rd_addr;
  logic [DATA_W-1:0] id_imm;
  logic [PC_W-1:0]   id_pc;

  logic [CTRL_W-1:0] ex_ctrl;
  logic [DATA_W-1:0] ex_rs_data;
  logic [DATA_W-1:0] ex_rd_data;
  logic [2:0]        ex_rs_addr;
  logic [2:0]        ex_rd_addr;
  logic [DATA_W-1:0] ex_imm;
  logic [PC_W-1:0]   ex_pc;
  logic              ex_valid;
  logic              pc_write;
  logic              if_id_write;
  logic [CNT_W-1:0]  bubble_count;

  // Decode side.
  modport master (
    output load_use_hazard, pop_jmp_hazard, flush, id_ctrl, id_rs_data, id_rd_data,
           id_rs_addr, id_rd_addr, id_imm, id_pc,
    input  ex_ctrl, ex_rs_data, ex_rd_data, ex_rs_addr, ex_rd_addr, ex_imm, ex_pc,
           ex_valid, pc_write, if_id_write, bubble_count
  );

  // Pipeline register side.
  modport slave (
    input  load_use_hazard, pop_jmp_hazard, flush, id_ctrl, id_rs_data, id_rd_data,
           id_rs_addr, id_rd_addr, id_imm, id_pc,
    output ex_ctrl, ex_rs_data, ex_rd_data, ex_rs_addr, ex_rd_addr, ex_imm, ex_pc,
           ex_valid, pc_write, if_id_write, bubble_count
  );
endinterface

// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register with a small stall FSM: load-use costs one bubble,
// pop-to-jump costs two; flush squashes without holding upstream.
module id_ex_stage_reg #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned PC_W   = 32,
  parameter int unsigned CTRL_W = 16,
  parameter int unsigned CNT_W  = 16
) (
  input logic                clk,
  input logic                rst,
  id_ex_stage_reg_if.slave   bus
);

  typedef enum logic [0:0] {StIdle, StHold1} state_e;

  state_e state_q, state_d;

  logic              bubble;
  logic              count_inc;
  logic              pc_write;
  logic              if_id_write;

  logic [CTRL_W-1:0] ctrl_q;
  logic [DATA_W-1:0] rs_data_q;
  logic [DATA_W-1:0] rd_data_q;
  logic [2:0]        rs_addr_q;
  logic [2:0]        rd_addr_q;
  logic [DATA_W-1:0] imm_q;
  logic [PC_W-1:0]   pc_q;
  logic              valid_q;
  logic [CNT_W-1:0]  count_q;

  always_comb begin
    state_d     = state_q;
    bubble      = 1'b0;
    count_inc   = 1'b0;
    pc_write    = 1'b1;
    if_id_write = 1'b1;
    if (!rst) begin
      unique case (state_q)
        StIdle: begin
          if (bus.flush) begin
            bubble = 1'b1;
          end else if (bus.pop_jmp_hazard) begin
            bubble      = 1'b1;
            count_inc   = 1'b1;
            pc_write    = 1'b0;
            if_id_write = 1'b0;
            state_d     = StHold1;
          end else if (bus.load_use_hazard) begin
            bubble      = 1'b1;
            count_inc   = 1'b1;
            pc_write    = 1'b0;
            if_id_write = 1'b0;
          end
        end
        StHold1: begin
          // Second pop/jump bubble; hazard inputs are ignored here.
          bubble  = 1'b1;
          state_d = StIdle;
          if (!bus.flush) begin
            count_inc   = 1'b1;
            pc_write    = 1'b0;
            if_id_write = 1'b0;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      ctrl_q    <= '0;
      rs_data_q <= '0;
      rd_data_q <= '0;
      rs_addr_q <= '0;
      rd_addr_q <= '0;
      imm_q     <= '0;
      pc_q      <= '0;
      valid_q   <= 1'b0;
      count_q   <= '0;
    end else begin
      state_q <= state_d;
      if (bubble) begin
        ctrl_q    <= '0;
        rs_data_q <= '0;
        rd_data_q <= '0;
        rs_addr_q <= '0;
        rd_addr_q <= '0;
        imm_q     <= '0;
        pc_q      <= '0;
        valid_q   <= 1'b0;
      end else begin
        ctrl_q    <= bus.id_ctrl;
        rs_data_q <= bus.id_rs_data;
        rd_data_q <= bus.id_rd_data;
        rs_addr_q <= bus.id_rs_addr;
        rd_addr_q <= bus.id_rd_addr;
        imm_q     <= bus.id_imm;
        pc_q      <= bus.id_pc;
        valid_q   <= 1'b1;
      end
      // Saturate rather than wrap so long runs stay visibly pegged.
      if (count_inc && (count_q != {CNT_W{1'b1}})) begin
        count_q <= count_q + 1'b1;
      end
    end
  end

  assign bus.ex_ctrl      = ctrl_q;
  assign bus.ex_rs_data   = rs_data_q;
  assign bus.ex_rd_data   = rd_data_q;
  assign bus.ex_rs_addr   = rs_addr_q;
  assign bus.ex_rd_addr   = rd_addr_q;
  assign bus.ex_imm       = imm_q;
  assign bus.ex_pc        = pc_q;
  assign bus.ex_valid     = valid_q;
  assign bus.bubble_count = count_q;
  assign bus.pc_write     = pc_write;
  assign bus.if_id_write  = if_id_write;

endmodule

// File: doc/id_ex_stage_reg.md
Name: id_ex_stage_reg

Overview:
- Decode-to-execute pipeline register that sits directly downstream of the decode-stage hazard detection logic.
- Consumes the load-use and pop/jump hazard selects from decode and turns them into bubble insertion into execute and hold signals for PC/IF-ID.
- Contains a small stall FSM, because the pop-to-jump hazard needs two bubbles and load-use needs one.
- Also keeps a saturating count of hazard bubbles for performance debug.

Parameters:
- DATA_W, 16, width of register operands and immediate.
- PC_W, 32, width of the PC carried to execute.
- CTRL_W, 16, width of the packed decoded control bundle (all-zero = NOP).
- CNT_W, 16, width of the hazard bubble counter.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- load_use_hazard  in  1  1 = load-use hazard on the current decode instruction.
- pop_jmp_hazard  in  1  1 = POP in execute feeds Rd of a jump in decode.
- flush  in  1  1 = taken branch/jump resolved; squash decode instruction.
- id_ctrl  in  CTRL_W  decoded control bundle.
- id_rs_data  in  DATA_W  source register value.
- id_rd_data  in  DATA_W  destination register value.
- id_rs_addr  in  3  source register index.
- id_rd_addr  in  3  destination register index.
- id_imm  in  DATA_W  immediate.
- id_pc  in  PC_W  PC of the decode instruction.
- ex_ctrl, ex_rs_data, ex_rd_data, ex_rs_addr, ex_rd_addr, ex_imm, ex_pc  out  matching widths  registered copies for execute.
- ex_valid  out  1  registered; 1 = ex_* holds a real instruction.
- pc_write  out  1  combinational; 0 = hold PC.
- if_id_write  out  1  combinational; 0 = hold the IF/ID register.
- bubble_count  out  CNT_W  registered saturating count of hazard bubbles.

Behaviour:
- Reset (rst=1 at a clock edge):
  - all ex_* go to 0, ex_valid=0, bubble_count=0, state=IDLE.
  - While rst=1, pc_write=1 and if_id_write=1.
- States:
  - IDLE: normal operation.
  - HOLD1: second bubble of a pop/jump stall.
- Priority each cycle: rst > flush > pop_jmp_hazard > load_use_hazard > normal capture.
- IDLE, flush=1:
  - insert bubble, stay IDLE.
  - pc_write=1, if_id_write=1 (upstream redirect/flush proceeds).
  - bubble_count not incremented.
- IDLE, pop_jmp_hazard=1:
  - insert bubble, go to HOLD1.
  - pc_write=0, if_id_write=0.
  - bubble_count+1.
- IDLE, load_use_hazard=1 (no pop_jmp_hazard):
  - insert bubble, stay IDLE.
  - pc_write=0, if_id_write=0.
  - bubble_count+1.
- IDLE, no hazard, no flush:
  - capture all id_* into ex_*, ex_valid=1.
  - pc_write=1, if_id_write=1.
- HOLD1:
  - hazard inputs are ignored.
  - flush=1: bubble, go to IDLE, pc_write=1, if_id_write=1, no count.
  - otherwise: bubble, go to IDLE, pc_write=0, if_id_write=0, bubble_count+1.
- Bubble definition: next edge ex_ctrl=0, ex_valid=0, and all data/address/pc fields=0. Zeroing keeps the bench deterministic.
- Latency: one cycle from id_* to ex_* when not stalled.
  - load-use: exactly 1 bubble.
  - pop/jump: exactly 2 consecutive bubbles.
  - The held decode instruction is re-evaluated in the cycle after the last bubble.
- Counter: bubble_count saturates at 2^CNT_W-1 with no wrap. Cleared only by rst.
- Hold outputs are purely combinational from state, rst, flush and the hazard inputs, so they act in the same cycle the hazard is flagged.
- Simultaneous load_use_hazard and pop_jmp_hazard: handled as pop_jmp (2 bubbles, counter +2 total).

Test Plan:
- Reset, then three back-to-back instructions with no hazards: ex_* matches each id_* one cycle later, ex_valid=1, pc_write=if_id_write=1, bubble_count=0.
- load_use_hazard=1 for one cycle with id_rd_addr=3:
  - that cycle pc_write=if_id_write=0.
  - next edge ex_ctrl=0, ex_valid=0, bubble_count=1.
  - following cycle captures the held instruction with ex_rd_addr=3.
- pop_jmp_hazard=1 pulse:
  - two bubble cycles, state IDLE→HOLD1→IDLE.
  - pc_write=0 for exactly 2 cycles, bubble_count=2.
  - then the jump instruction is captured.
- flush asserted in HOLD1:
  - bubble inserted, returns to IDLE.
  - pc_write=if_id_write=1 in that cycle.
  - bubble_count increments only for the first bubble (=1).
- Both hazards plus flush high together: flush wins, giving a bubble, no hold, no count.
- Both hazards high together, no flush: 2 bubbles, counter +2.
- CNT_W=2, six load-use stalls: bubble_count reads 1, 2, 3, 3, 3, 3.
- Assert rst mid-HOLD1: next edge gives state IDLE, ex_valid=0, count=0, and pc_write=1 during rst.
